// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor:
// stage count derivation and parameter legality checks.
package adder_pkg;

    // One pipeline stage per K-bit slice of the N-bit operands.
    function automatic int stage_count(input int n, input int k);
        return n / k;
    endfunction

    // Operands must be at least 2 bits and split evenly into K-bit slices.
    function automatic bit params_legal(input int n, input int k);
        return (n >= 2) && (k >= 1) && (k <= n) && ((n % k) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational K-bit carry-lookahead slice. Every carry is formed directly
// from generate/propagate terms and c_in rather than rippling bit to bit.
module cla_block #(
    parameter int K = 8
) (
    input  logic         c_in,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic [K-1:0] s,
    output logic         c_out,
    output logic         c_msb
);

    logic [K-1:0] g;
    logic [K-1:0] p;
    logic [K:0]   c;
    logic         acc;
    logic         pp;

    // Lookahead carries: c[i+1] = OR_k (g[k] & p[i..k+1]) | (p[i..0] & c_in).
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b1;
        c[0] = c_in;
        for (int unsigned i = 0; i < K; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int unsigned k = 0; k <= i; k++) begin
                acc = acc | (g[i-k] & pp);
                pp  = pp & p[i-k];
            end
            c[i+1] = acc | (pp & c_in);
        end
    end

    assign s     = p ^ c[K-1:0];
    assign c_out = c[K];
    assign c_msb = c[K-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined N-bit adder/subtractor: one K-bit carry-lookahead slice per
// stage, valid/ready handshake, whole-pipe stall when the result is held,
// optional signed saturation of the sum.
module pipe_cla_addsub
    import adder_pkg::*;
#(
    parameter int N   = 32,
    parameter int K   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         C_in,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         C_out,
    output logic         overflow
);

    localparam int S = stage_count(N, K);
    localparam int L = S - 1;

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = ~SAT_MAX;

    if (!params_legal(N, K)) begin : g_param_check
        $error("pipe_cla_addsub: N must be >= 2 and a multiple of K");
    end

    logic         stall;
    logic         adv;
    logic [N-1:0] y_eff;
    logic         c_first;

    // Subtraction is x + ~y + 1, so C_in is ignored when sub is set.
    always_comb begin
        y_eff   = sub ? ~y : y;
        c_first = sub | C_in;
    end

    // Only a held result stalls; bubbles never block a later beat.
    always_comb begin
        stall    = out_valid && !out_ready;
        adv      = !stall;
        in_ready = !stall;
    end

    for (genvar j = 0; j < S; j++) begin : g_stage
        // Operand bits still waiting for later stages after this one.
        localparam int RW = N - (j + 1) * K;

        logic                 v_in;
        logic [K-1:0]         a_in;
        logic [K-1:0]         b_in;
        logic                 c_in;
        logic [(j+1)*K-1:0]   s_cat;
        logic [K-1:0]         s_new;
        logic                 c_new;
        logic                 cm_new;
        logic                 load;
        logic                 v_d;
        logic                 v_q;
        logic [(j+1)*K-1:0]   s_d;
        logic [(j+1)*K-1:0]   s_q;
        logic                 c_d;
        logic                 c_q;

        if (j == 0) begin : g_src
            assign v_in  = in_valid;
            assign a_in  = x[K-1:0];
            assign b_in  = y_eff[K-1:0];
            assign c_in  = c_first;
            assign s_cat = s_new;
        end else begin : g_src
            assign v_in  = g_stage[j-1].v_q;
            assign a_in  = g_stage[j-1].g_rest.a_q[K-1:0];
            assign b_in  = g_stage[j-1].g_rest.b_q[K-1:0];
            assign c_in  = g_stage[j-1].c_q;
            assign s_cat = {s_new, g_stage[j-1].s_q};
        end

        cla_block #(.K(K)) u_cla (
            .c_in  (c_in),
            .a     (a_in),
            .b     (b_in),
            .s     (s_new),
            .c_out (c_new),
            .c_msb (cm_new)
        );

        assign load = adv && v_in;

        // Advance on !stall; data only captured for real beats, held otherwise.
        always_comb begin
            v_d = adv ? v_in : v_q;
            s_d = load ? s_cat : s_q;
            c_d = load ? c_new : c_q;
        end

        // Valid, completed sum bits and slice carry-out for this stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                v_q <= v_d;
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (RW > 0) begin : g_rest
            logic [RW-1:0] a_src;
            logic [RW-1:0] b_src;
            logic [RW-1:0] a_d;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_d;
            logic [RW-1:0] b_q;
            // Carry into the MSB only matters in the final slice.
            logic          unused_cm;

            assign unused_cm = cm_new;

            if (j == 0) begin : g_pick
                assign a_src = x[N-1:K];
                assign b_src = y_eff[N-1:K];
            end else begin : g_pick
                assign a_src = g_stage[j-1].g_rest.a_q[RW+K-1:K];
                assign b_src = g_stage[j-1].g_rest.b_q[RW+K-1:K];
            end

            // Unconsumed operand bits move forward with their beat.
            always_comb begin
                a_d = load ? a_src : a_q;
                b_d = load ? b_src : b_q;
            end

            // Operand storage needs no reset: qualified by the stage valid.
            always_ff @(posedge clk) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end else begin : g_last
            logic cm_d;
            logic cm_q;
            logic xm_d;
            logic xm_q;

            // Capture carry into the result MSB and the sign of x.
            always_comb begin
                cm_d = load ? cm_new : cm_q;
                xm_d = load ? a_in[K-1] : xm_q;
            end

            // Reset so overflow and saturation read 0 while in reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cm_q <= 1'b0;
                    xm_q <= 1'b0;
                end else begin
                    cm_q <= cm_d;
                    xm_q <= xm_d;
                end
            end
        end
    end

    logic [N-1:0] raw_sum;
    logic         cm_fin;
    logic         xm_fin;

    assign out_valid = g_stage[L].v_q;
    assign raw_sum   = g_stage[L].s_q;
    assign C_out     = g_stage[L].c_q;
    assign cm_fin    = g_stage[L].g_last.cm_q;
    assign xm_fin    = g_stage[L].g_last.xm_q;
    assign overflow  = C_out ^ cm_fin;

    // Clamp toward the sign of x on signed overflow when saturation is enabled.
    always_comb begin
        sum = raw_sum;
        if (SAT && overflow) begin
            sum = xm_fin ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand width in bits (N >= 2).
REQ-002 The block SHALL have parameter K, default 8, meaning bits resolved per pipeline stage; N SHALL be a multiple of K.
REQ-003 The block SHALL have parameter SAT, default 0, meaning that 1 enables signed saturation of sum on overflow.
REQ-004 Port list, one per line, SHALL be:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts beat this cycle.
- sub  input  1  0 = x+y+C_in, 1 = x-y (computed as x+~y+1, C_in ignored).
- C_in  input  1  carry-in for add.
- x  input  N  operand A.
- y  input  N  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  N  result.
- C_out  output  1  unsigned carry-out (borrow-not for sub).
- overflow  output  1  signed overflow, carry into MSB xor carry out of MSB.

Function
REQ-005 Stages S = N/K; stage j SHALL add bits [jK+K-1:jK] using K-bit carry-lookahead with the carry registered from stage j-1.
REQ-006 Each stage register SHALL hold a valid bit, the remaining unconsumed operand bits, completed sum bits, carry, and the MSB carry-in once known.
REQ-007 Latency SHALL be exactly S cycles from accepted input to out_valid with no stall; throughput SHALL be one beat per cycle.
REQ-008 A beat SHALL be accepted when in_valid && in_ready; a result SHALL be delivered when out_valid && out_ready.
REQ-009 stall = out_valid && !out_ready; in_ready SHALL equal !stall; on stall every stage register SHALL hold its value.
REQ-010 Bubbles SHALL propagate as invalid stages; a bubble SHALL not block a later beat (no stall unless output is held).
REQ-011 sum, C_out, and overflow SHALL remain stable while out_valid && !out_ready.
REQ-012 With SAT=1 and overflow=1, sum SHALL be 2^(N-1)-1 if the MSB of x is 0, else -2^(N-1); overflow SHALL still report 1 and C_out SHALL be unmodified.
REQ-013 Beats SHALL emerge in acceptance order; no beat SHALL be dropped or duplicated.
REQ-014 Simultaneous accept and deliver SHALL be legal in the same cycle at full occupancy.

Reset
REQ-015 On rst_n low, all stage valid bits SHALL clear asynchronously; out_valid, sum, C_out, and overflow SHALL be 0.
REQ-016 in_ready SHALL be 1 whenever rst_n is low and after release.
REQ-017 Reset mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear afterwards.
REQ-018 Data registers need no reset beyond the outputs named in REQ-015.

Structure
REQ-019 Package adder_pkg SHALL hold the stage-count function S = N/K and the parameter legality checks.
REQ-020 The block SHALL instantiate sub-module cla_block, a combinational K-bit carry-lookahead slice with c_in, a, b, s, c_out, and c_msb (the carry into the slice MSB), once per stage.

Verification
REQ-021 With N=32, K=8, SAT=0, add 0xFFFFFFFF+0x00000001, C_in=0 -> 4 cycles later sum=0x00000000, C_out=1, overflow=0.
REQ-022 With N=32, K=8, SAT=0, sub x=0x80000000, y=0x00000001 -> sum=0x7FFFFFFF, C_out=1, overflow=1; with SAT=1 -> sum=0x80000000, overflow=1.
REQ-023 Stream 10 back-to-back adds with out_ready held 1 -> 10 results on consecutive cycles starting cycle 4, in order.
REQ-024 With 4 beats in flight, drop out_ready for 3 cycles -> in_ready=0 and output held stable for those cycles; all 4 results delivered in order after release.
REQ-025 Assert rst_n low for 1 cycle with 3 beats in flight -> out_valid=0 immediately; no stale result after release; the next accepted beat returns after 4 cycles.
REQ-026 Random add/sub with random valid/ready over 10k beats -> every result matches a reference model of (x+y+C_in) or (x+~y+1) mod 2^32, with C_out and overflow correct.
